// File: rtl/data_checker.sv
// Integrity monitor for an incrementing counter stream: locks onto the sequence,
// flags mismatches, and keeps a sticky flag plus saturating word/error counters.
module data_checker #(
  parameter int DATA_WIDTH    = 8,
  parameter int CNT_WIDTH     = 16,
  parameter int LOCK_THRESH   = 2,
  parameter int RESYNC_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] i_Data,
  input  logic                  i_Data_Valid,
  input  logic                  i_Clear,
  output logic                  o_Locked,
  output logic                  o_Error,
  output logic                  o_Error_Sticky,
  output logic [CNT_WIDTH-1:0]  o_Word_Count,
  output logic [CNT_WIDTH-1:0]  o_Error_Count,
  output logic [DATA_WIDTH-1:0] o_Last_Data,
  output logic [1:0]            o_State
);

  localparam int MW = (LOCK_THRESH   < 1) ? 1 : $clog2(LOCK_THRESH + 1);
  localparam int RW = (RESYNC_THRESH < 1) ? 1 : $clog2(RESYNC_THRESH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2,
    S_SLIP    = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_expected, w_exp_nxt;
  logic [MW-1:0]         r_match_cnt, w_match_nxt;
  logic [RW-1:0]         r_miss_cnt, w_miss_nxt;
  logic                  r_error, w_err_nxt;
  logic                  r_sticky;
  logic [CNT_WIDTH-1:0]  r_word_cnt, r_err_cnt;
  logic [DATA_WIDTH-1:0] r_last_data;

  logic                  w_wc_inc, w_ec_inc;
  logic                  w_match;
  logic [DATA_WIDTH-1:0] w_data_inc, w_exp_inc;
  logic [MW-1:0]         w_match_inc;
  logic [RW-1:0]         w_miss_inc;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_match     = (i_Data == r_expected);
  assign w_data_inc  = i_Data + DATA_WIDTH'(1);
  assign w_exp_inc   = r_expected + DATA_WIDTH'(1);
  assign w_match_inc = r_match_cnt + MW'(1);
  assign w_miss_inc  = r_miss_cnt + RW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_expected;
    w_match_nxt = r_match_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_err_nxt   = 1'b0;
    w_wc_inc    = 1'b0;
    w_ec_inc    = 1'b0;
    if (i_Data_Valid) begin
      case (r_state)
        S_IDLE: begin
          w_exp_nxt   = w_data_inc;
          w_match_nxt = '0;
          w_state_nxt = S_ACQUIRE;
        end
        S_ACQUIRE: begin
          w_exp_nxt = w_data_inc;
          if (w_match) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == MW'(LOCK_THRESH)) begin
              w_state_nxt = S_LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            w_match_nxt = '0;
          end
        end
        S_LOCKED: begin
          w_wc_inc = 1'b1;
          if (w_match) begin
            w_exp_nxt = w_data_inc;
          end else begin
            w_err_nxt  = 1'b1;
            w_ec_inc   = 1'b1;
            w_miss_nxt = RW'(1);
            if (RESYNC_THRESH == 1) begin
              // A single miss already exhausts the resync budget: restart acquisition on this word.
              w_exp_nxt   = w_data_inc;
              w_match_nxt = '0;
              w_state_nxt = S_ACQUIRE;
            end else begin
              w_exp_nxt   = w_exp_inc;
              w_state_nxt = S_SLIP;
            end
          end
        end
        default: begin
          w_wc_inc = 1'b1;
          if (w_match) begin
            w_miss_nxt  = '0;
            w_exp_nxt   = w_data_inc;
            w_state_nxt = S_LOCKED;
          end else begin
            w_err_nxt  = 1'b1;
            w_ec_inc   = 1'b1;
            w_miss_nxt = w_miss_inc;
            if (w_miss_inc == RW'(RESYNC_THRESH)) begin
              w_exp_nxt   = w_data_inc;
              w_match_nxt = '0;
              w_state_nxt = S_ACQUIRE;
            end else begin
              // Flywheel: keep predicting from the old sequence while slipping.
              w_exp_nxt = w_exp_inc;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_expected  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_error     <= 1'b0;
      r_last_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_expected  <= w_exp_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_error     <= w_err_nxt;
      if (i_Data_Valid) r_last_data <= i_Data;
    end
  end

  // Clear wins over any same-cycle increment or sticky set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sticky   <= 1'b0;
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (i_Clear) begin
      r_sticky   <= 1'b0;
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_err_nxt) r_sticky   <= 1'b1;
      if (w_wc_inc)  r_word_cnt <= sat_inc(r_word_cnt);
      if (w_ec_inc)  r_err_cnt  <= sat_inc(r_err_cnt);
    end
  end

  assign o_Locked       = r_state[1];
  assign o_Error        = r_error;
  assign o_Error_Sticky = r_sticky;
  assign o_Word_Count   = r_word_cnt;
  assign o_Error_Count  = r_err_cnt;
  assign o_Last_Data    = r_last_data;
  assign o_State        = r_state;

endmodule

// File: tb/tb_data_checker.sv
// Scoreboard bench for data_checker: a reference model queues expected outputs per
// driven cycle; they are popped and compared just after the sampling edge.
module tb_data_checker;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int LT = 2;
  localparam int RT = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] i_Data = '0;
  logic          i_Data_Valid = 1'b0;
  logic          i_Clear = 1'b0;
  logic          o_Locked, o_Error, o_Error_Sticky;
  logic [CW-1:0] o_Word_Count, o_Error_Count;
  logic [DW-1:0] o_Last_Data;
  logic [1:0]    o_State;

  data_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .LOCK_THRESH(LT), .RESYNC_THRESH(RT)) dut (
    .clk(clk), .resetn(resetn), .i_Data(i_Data), .i_Data_Valid(i_Data_Valid),
    .i_Clear(i_Clear), .o_Locked(o_Locked), .o_Error(o_Error),
    .o_Error_Sticky(o_Error_Sticky), .o_Word_Count(o_Word_Count),
    .o_Error_Count(o_Error_Count), .o_Last_Data(o_Last_Data), .o_State(o_State)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]    state;
    logic          err;
    logic          sticky;
    logic [CW-1:0] wc;
    logic [CW-1:0] ec;
    logic [DW-1:0] last;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [1:0]    m_state;
  logic [DW-1:0] m_exp, m_last;
  int            m_match, m_miss;
  logic          m_err, m_sticky;
  logic [CW-1:0] m_wc, m_ec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [CW-1:0] msat(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) return v;
    return v + 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_exp = 0; m_last = 0; m_match = 0; m_miss = 0;
    m_err = 0; m_sticky = 0; m_wc = 0; m_ec = 0;
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic clr);
    logic hit;
    m_err = 0;
    if (v) begin
      m_last = d;
      hit = (d == m_exp);
      if (m_state == 0) begin
        m_exp = d + 1; m_match = 0; m_state = 1;
      end else if (m_state == 1) begin
        if (hit) begin
          m_match++;
          if (m_match == LT) begin m_state = 2; m_miss = 0; end
        end else m_match = 0;
        m_exp = d + 1;
      end else begin
        m_wc = msat(m_wc);
        if (hit) begin
          m_exp = d + 1; m_miss = 0; m_state = 2;
        end else begin
          m_err = 1; m_sticky = 1; m_ec = msat(m_ec);
          m_miss = (m_state == 2) ? 1 : m_miss + 1;
          if (m_miss == RT) begin
            m_exp = d + 1; m_match = 0; m_state = 1;
          end else begin
            m_exp = m_exp + 1; m_state = 3;
          end
        end
      end
    end
    if (clr) begin m_wc = 0; m_ec = 0; m_sticky = 0; end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_state"},  o_State,        e.state);
    chk({tag, "_locked"}, o_Locked,       e.state[1]);
    chk({tag, "_err"},    o_Error,        e.err);
    chk({tag, "_sticky"}, o_Error_Sticky, e.sticky);
    chk({tag, "_wc"},     o_Word_Count,   e.wc);
    chk({tag, "_ec"},     o_Error_Count,  e.ec);
    chk({tag, "_last"},   o_Last_Data,    e.last);
  endtask

  task automatic send(input logic v, input logic [DW-1:0] d, input logic clr, input string tag);
    exp_t e;
    @(negedge clk);
    i_Data_Valid = v; i_Data = d; i_Clear = clr;
    model_step(v, d, clr);
    e.state = m_state; e.err = m_err; e.sticky = m_sticky;
    e.wc = m_wc; e.ec = m_ec; e.last = m_last;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    i_Data_Valid = 1'b0; i_Clear = 1'b0;
    compare_out(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; i_Data_Valid = 1'b0; i_Clear = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"},  o_State, 0);
    chk({tag, "_locked"}, o_Locked, 0);
    chk({tag, "_err"},    o_Error, 0);
    chk({tag, "_sticky"}, o_Error_Sticky, 0);
    chk({tag, "_wc"},     o_Word_Count, 0);
    chk({tag, "_ec"},     o_Error_Count, 0);
    chk({tag, "_last"},   o_Last_Data, 0);
  endtask

  initial begin
    model_reset();
    #12;
    chk_all_zero("rst");
    do_reset();

    // Clean stream 0..9
    for (int i = 0; i < 10; i++) begin
      send(1, DW'(i), 0, "clean");
      if (i == 1) chk("clean_notlocked_w1", o_Locked, 0);
      if (i == 2) chk("clean_locked_w2", o_Locked, 1);
    end
    chk("clean_wc7", o_Word_Count, 7);
    chk("clean_ec0", o_Error_Count, 0);
    chk("clean_sticky0", o_Error_Sticky, 0);

    // Wrap-around 0xFC..0x03
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(1, DW'(8'hFC + i), 0, "wrap");
      if (i == 2) chk("wrap_lock_fe", o_Locked, 1);
      chk("wrap_noerr", o_Error, 0);
    end
    chk("wrap_wc5", o_Word_Count, 5);

    // Single corruption
    do_reset();
    send(1, 7, 0, "sc"); send(1, 8, 0, "sc"); send(1, 9, 0, "sc");
    send(1, 10, 0, "sc"); send(1, 11, 0, "sc");
    send(1, 8'h55, 0, "sc");
    chk("sc_err_pulse", o_Error, 1);
    chk("sc_slip", o_State, 3);
    chk("sc_locked_in_slip", o_Locked, 1);
    send(1, 13, 0, "sc");
    chk("sc_relock", o_State, 2);
    chk("sc_err_low", o_Error, 0);
    send(1, 14, 0, "sc");
    chk("sc_ec1", o_Error_Count, 1);
    chk("sc_sticky1", o_Error_Sticky, 1);

    // Sequence jump
    do_reset();
    send(1, 18, 0, "jmp"); send(1, 19, 0, "jmp"); send(1, 20, 0, "jmp");
    chk("jmp_locked20", o_State, 2);
    for (int i = 100; i <= 105; i++) begin
      send(1, DW'(i), 0, "jmp");
      if (i <= 103) chk("jmp_errpulse", o_Error, 1);
      if (i == 103) chk("jmp_acq", o_State, 1);
      if (i == 104) chk("jmp_unlocked", o_Locked, 0);
    end
    chk("jmp_relock", o_State, 2);
    chk("jmp_ec4", o_Error_Count, 4);

    // Valid gaps 1,0,0,1
    for (int i = 106; i < 112; i++) begin
      send(1, DW'(i), 0, "gap");
      chk("gap_noerr", o_Error, 0);
      send(0, 8'hAA, 0, "gap_idle");
      send(0, 8'h33, 0, "gap_idle");
    end
    chk("gap_ec4", o_Error_Count, 4);

    // Clear on a mismatch cycle
    send(1, 8'h00, 1, "clr");
    chk("clr_err_pulse", o_Error, 1);
    chk("clr_wc0", o_Word_Count, 0);
    chk("clr_ec0", o_Error_Count, 0);
    chk("clr_sticky0", o_Error_Sticky, 0);
    send(0, 0, 0, "clr_idle");
    chk("clr_err_gone", o_Error, 0);

    // Word counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) send(1, DW'(i), 0, "sat");
    chk("sat_wc_ff", o_Word_Count, 8'hFF);
    send(1, DW'(300), 0, "sat");
    chk("sat_wc_hold", o_Word_Count, 8'hFF);

    // Asynchronous reset while locked
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    chk_all_zero("arst");
    @(negedge clk);
    resetn = 1'b1;
    send(1, 50, 0, "rs"); send(1, 51, 0, "rs");
    chk("rs_notlocked51", o_Locked, 0);
    send(1, 52, 0, "rs");
    chk("rs_locked52", o_Locked, 1);
    chk("rs_sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
